serial_number_transmitter_fsm: RTL and testbench

Transmit end of the serial-number bit stream consumed by the serial divisibility checkers. Accepts a W-bit parallel number on a valid/ready load port and shifts it out one bit per transfer, MSB first, on a valid/ready bit port. Tracks the running remainder mod 5 of the bits sent so far, so the bench and downstream logic can cross-check the receiver's div-by-5 result. Sits between a number source (bench or register block) and a serial_divisibility_by_*_using_fsm instance.

---
 rtl/serial_number_transmitter_fsm.sv | 87 ++++++++
 tb/tb_serial_number_transmitter_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_number_transmitter_fsm.sv
// Parallel-in, serial-out transmitter: shifts a W-bit word out MSB first over
// valid/ready and tracks the running remainder mod 5 of the bits sent.
module serial_number_transmitter_fsm #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_bit,
  output logic         out_last,
  output logic [2:0]   rem5,
  output logic         word_done
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [2:0]     rem_q,   rem_d;
  logic           done_q,  done_d;
  logic [3:0]     acc;

  // Outputs decode registers only; out_ready never reaches them combinationally.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SEND);
  assign out_bit   = (state_q == SEND) & shreg_q[W-1];
  assign out_last  = (state_q == SEND) & (cnt_q == '0);
  assign rem5      = rem_q;
  assign word_done = done_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    acc     = {rem_q, out_bit};
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = CW'(W - 1);
          rem_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          shreg_d = shreg_q << 1;
          // 2*rem + bit lies in 0..9, so one conditional subtract reduces it mod 5
          rem_d   = (acc >= 4'd5) ? 3'(acc - 4'd5) : acc[2:0];
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_number_transmitter_fsm.sv
// Scoreboard bench: the driver queues the expected bit stream for each load,
// and a negedge monitor pops and checks it on every bit transfer.
module tb_serial_number_transmitter_fsm;

  localparam int unsigned W = 16;

  typedef struct {
    int bitv;
    int last;
    int rem_before;
    int fin;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, out_bit, out_last, word_done;
  logic [W-1:0] in_data;
  logic [2:0]   rem5;

  logic         in_valid1, in_ready1, out_valid1, out_ready1, out_bit1, out_last1, word_done1;
  logic [0:0]   in_data1;
  logic [2:0]   rem51;

  int   nvec = 0;
  int   nerr = 0;
  int   mode = 0;
  int   cyc  = 0;
  exp_t q[$];
  int   pend = 0;
  int   pend_rem = 0;

  always #5 clk = ~clk;

  serial_number_transmitter_fsm #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_last(out_last),
    .rem5(rem5), .word_done(word_done)
  );

  serial_number_transmitter_fsm #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_bit(out_bit1), .out_last(out_last1),
    .rem5(rem51), .word_done(word_done1)
  );

  task automatic chk(input string nm, input int act, input int expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: k-th bit sent is d[W-1-k]; remainder before it is the value of
  // the already-sent prefix (d >> (W-k)) mod 5.
  task automatic push_word(input int unsigned d);
    exp_t e;
    for (int unsigned k = 0; k < W; k++) begin
      e.bitv       = int'((d >> (W - 1 - k)) & 1);
      e.last       = (k == W - 1) ? 1 : 0;
      e.rem_before = (k == 0) ? 0 : int'((d >> (W - k)) % 5);
      e.fin        = int'(d % 5);
      q.push_back(e);
    end
  endtask

  task automatic load(input int unsigned d, input int keep_valid);
    int ok = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = W'(d);
    for (int i = 0; i < 200 && ok == 0; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push_word(d);
        ok = 1;
      end
    end
    if (ok == 0) begin
      nerr++;
      $display("FAIL load_timeout: in_ready never seen for %h", d);
    end
    @(posedge clk); #1;
    if (keep_valid == 0) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int ok = 0;
    for (int i = 0; i < 2000 && ok == 0; i++) begin
      @(negedge clk);
      if (q.size() == 0 && pend == 0 && !out_valid) ok = 1;
    end
    if (ok == 0) begin
      nerr++;
      $display("FAIL idle_timeout: %0d bits still queued", q.size());
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      if (pend != 0) begin
        chk("word_done", int'(word_done), 1);
        chk("final_rem5", int'(rem5), pend_rem);
        chk("in_ready_after", int'(in_ready), 1);
        pend = 0;
      end else begin
        chk("word_done_quiet", int'(word_done), 0);
      end
      chk("in_ready_vs_valid", int'(in_ready), int'(!out_valid));
      if (out_valid) begin
        if (q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_bit: got out_valid=1 expected empty scoreboard");
        end else begin
          chk("out_bit", int'(out_bit), q[0].bitv);
          chk("out_last", int'(out_last), q[0].last);
          chk("rem5_run", int'(rem5), q[0].rem_before);
          if (out_ready) begin
            if (q[0].last != 0) begin
              pend = 1;
              pend_rem = q[0].fin;
            end
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int ok;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bit", int'(out_bit), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_rem5", int'(rem5), 0);
    chk("rst_word_done", int'(word_done), 0);
    @(posedge clk); #1 rst = 1'b1;

    mode = 0;
    load(32'h000A, 0);
    wait_idle();

    mode = 1;
    load(32'hFFFF, 0);
    wait_idle();

    // Asynchronous reset mid-word, right after the 5th transfer edge
    mode = 0;
    load(32'h8003, 0);
    ok = 0;
    for (int i = 0; i < 100 && ok == 0; i++) begin
      @(negedge clk);
      if (q.size() == W - 5) ok = 1;
    end
    if (ok == 0) begin
      nerr++;
      $display("FAIL reset_wait: queue size %0d", q.size());
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_rem5", int'(rem5), 0);
    q.delete();
    pend = 0;
    #1 rst = 1'b1;
    load(32'h8003, 0);
    wait_idle();

    // Back-to-back with in_valid held: second load only once in_ready returns
    load(32'h1234, 1);
    in_data = W'(32'h0007);
    ok = 0;
    for (int i = 0; i < 100 && ok == 0; i++) begin
      @(negedge clk);
      if (in_ready) begin
        chk("b2b_done_with_ready", int'(word_done), 1);
        push_word(32'h0007);
        ok = 1;
      end
    end
    if (ok == 0) begin
      nerr++;
      $display("FAIL b2b_timeout: second word never accepted");
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_idle();

    mode = 2;
    for (int n = 0; n < 200; n++) begin
      load($urandom_range(0, 65535), 0);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    // W=1 instance
    @(posedge clk); #1;
    in_valid1 = 1'b1; in_data1 = 1'b1; out_ready1 = 1'b0;
    @(posedge clk); #1 in_valid1 = 1'b0;
    @(negedge clk);
    chk("w1_out_valid", int'(out_valid1), 1);
    chk("w1_out_bit", int'(out_bit1), 1);
    chk("w1_out_last", int'(out_last1), 1);
    chk("w1_in_ready", int'(in_ready1), 0);
    @(posedge clk); #1 out_ready1 = 1'b1;
    @(posedge clk); #1 out_ready1 = 1'b0;
    @(negedge clk);
    chk("w1_word_done", int'(word_done1), 1);
    chk("w1_rem5", int'(rem51), 1);
    chk("w1_in_ready_after", int'(in_ready1), 1);
    @(negedge clk);
    chk("w1_word_done_once", int'(word_done1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
